serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
- Upstream stage of the deserializer, clocked in the 100 kHz domain.
- Accepts parallel words over a valid/ready handshake.
- Shifts each word out MSB-first, one bit per clock, on the deserializer's data_in/write_in pair.
- Holds off new frames while the deserializer reports busy (status high, awaiting ack from the queue side). This gives the deserializer-to-queue chain a deterministic, rate-limited source.

Parameters:
- DATA_WIDTH, 8, bits per frame; must match the deserializer word width.
- GAP_CYCLES, 2, idle cycles with write_out low inserted after every frame; minimum 1.
- CNT_WIDTH, 16, width of the sent-frame counter.

Ports:
- clock_100KHZ  input  1  block clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_data_in  input  DATA_WIDTH  parallel word to transmit.
- tx_valid_in  input  1  tx_data_in is valid.
- tx_ready_out  output  1  block will accept tx_data_in this cycle.
- status_in  input  1  deserializer status_out; high = deserializer holding a word, do not start a frame.
- data_out  output  1  serial bit, connects to deserializer data_in.
- write_out  output  1  high while data_out carries a valid bit, connects to deserializer write_in.
- busy_out  output  1  high in any state other than IDLE.
- frames_sent_out  output  CNT_WIDTH  count of completed frames, wraps modulo 2^CNT_WIDTH.

Behaviour:
- All outputs are registered, except tx_ready_out, which is combinational: (state==IDLE) && !status_in.
- Reset asserted, effective immediately (asynchronous):
  - state=IDLE; data_out=0; write_out=0; busy_out=0; frames_sent_out=0; shift register=0; bit counter=0.
- States: IDLE, SEND, GAP.
- IDLE:
  - A handshake occurs when tx_valid_in && tx_ready_out at a rising edge.
  - On handshake: load tx_data_in into the shift register, bit counter=0, go to SEND.
  - No handshake while status_in=1, regardless of tx_valid_in.
  - tx_data_in is ignored outside a handshake.
- SEND:
  - First bit (tx_data_in[DATA_WIDTH-1]) appears on data_out with write_out=1 in the cycle after the handshake edge (latency 1).
  - Each edge presents the next bit. write_out stays high for exactly DATA_WIDTH consecutive cycles.
  - The bit counter counts 0..DATA_WIDTH-1. On the edge after the last bit is presented, go to GAP and increment frames_sent_out.
- GAP:
  - write_out=0, data_out=0 for exactly GAP_CYCLES cycles, then IDLE.
  - The gap gives the deserializer time to raise status_in before the next frame can start.
- status_in during SEND or GAP: ignored; an in-flight frame always completes.
- Back-to-back traffic: minimum frame period is 1+DATA_WIDTH+GAP_CYCLES cycles (handshake cycle + bits + gap). With defaults this is 11 cycles.
- Counter wrap: frames_sent_out at 2^CNT_WIDTH-1 increments to 0 with no flag.
- Reset mid-frame:
  - write_out drops in the same time step; the partial frame is discarded.
  - The frame is not counted and is not resent after reset.
- tx_valid_in deasserted before a handshake: no effect, no frame.
- The producer must hold tx_data_in stable while tx_valid_in is high and tx_ready_out is low.

Decomposition:
- Shared package mc_pkg holds:
  - localparam DATA_WIDTH default (8), shared with deserializer and queue;
  - typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;
  - localparam default GAP_CYCLES.
- No sub-module. The shift register, bit counter, gap counter and frame counter live in one always_ff with a separate next-state always_comb.

Test Plan:
- Reset, then tx_data_in=8'hA5, tx_valid_in=1 for one cycle with status_in=0:
  - handshake at edge N;
  - write_out high for edges N+1..N+8 with data_out=1,0,1,0,0,1,0,1;
  - write_out low for 2 cycles;
  - frames_sent_out=1; tx_ready_out returns high at N+11.
- status_in=1 with tx_valid_in=1, tx_data_in=8'h3C for 20 cycles:
  - tx_ready_out=0 and write_out=0 throughout.
  - Drop status_in: frame 8'h3C (0,0,1,1,1,1,0,0) starts 1 cycle after the handshake.
- Words 8'h01, 8'hFF, 8'h80 held valid continuously with status_in=0:
  - three frames at period 11 cycles;
  - bitstreams exact; frames_sent_out ends at 3.
- Raise status_in at bit 3 of frame 8'hF0:
  - frame completes all 8 bits; frames_sent_out increments;
  - no new handshake until status_in=0.
- Assert reset asynchronously (between edges) at bit 5 of 8'h55:
  - write_out=0, busy_out=0, frames_sent_out=0 before the next edge.
  - After release, a new 8'h0F transmits cleanly and the count becomes 1.
- Preload the counter path by sending 2^CNT_WIDTH frames (CNT_WIDTH overridden to 3, 8 frames):
  - frames_sent_out reads 7 then wraps to 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the serial frame transmitter / deserializer / queue chain.
package mc_pkg;

    // Word width shared by the transmitter, deserializer and queue.
    localparam int DATA_WIDTH = 8;

    // Default number of idle cycles inserted after every transmitted frame.
    localparam int GAP_CYCLES = 2;

    // Transmitter control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: accepts parallel words over valid/ready and
// shifts them out MSB-first, one bit per clock, followed by an idle gap.
module serial_frame_tx
    import mc_pkg::*;
#(
    parameter int DATA_WIDTH = mc_pkg::DATA_WIDTH,
    parameter int GAP_CYCLES = mc_pkg::GAP_CYCLES,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock_100KHZ,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic                  tx_valid_in,
    output logic                  tx_ready_out,
    input  logic                  status_in,
    output logic                  data_out,
    output logic                  write_out,
    output logic                  busy_out,
    output logic [CNT_WIDTH-1:0]  frames_sent_out
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    tx_state_t             state_q;
    tx_state_t             state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [GAP_W-1:0]      gap_cnt_q;
    logic                  handshake;
    logic                  last_bit;
    logic                  last_gap;

    // A new frame may only start from IDLE while the deserializer is free.
    assign tx_ready_out = (state_q == IDLE) && !status_in;
    assign handshake    = tx_valid_in && tx_ready_out;
    assign last_bit     = (bit_cnt_q == LAST_BIT);
    assign last_gap     = (gap_cnt_q == LAST_GAP);

    // Next-state logic; status_in only gates the start of a frame.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (handshake) state_d = SEND;
            SEND:    if (last_bit)  state_d = GAP;
            GAP:     if (last_gap)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register, bit/gap counters, frame counter and registered outputs.
    // The first bit is driven straight from tx_data_in at the handshake edge;
    // the shift register then holds the remaining bits, MSB-aligned.
    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            gap_cnt_q       <= '0;
            data_out        <= 1'b0;
            write_out       <= 1'b0;
            busy_out        <= 1'b0;
            frames_sent_out <= '0;
        end else begin
            busy_out <= (state_d != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (handshake) begin
                        data_out  <= tx_data_in[DATA_WIDTH-1];
                        write_out <= 1'b1;
                        shift_q   <= tx_data_in << 1;
                        bit_cnt_q <= '0;
                    end
                end
                SEND: begin
                    if (last_bit) begin
                        data_out        <= 1'b0;
                        write_out       <= 1'b0;
                        gap_cnt_q       <= '0;
                        frames_sent_out <= frames_sent_out + CNT_WIDTH'(1);
                    end else begin
                        data_out  <= shift_q[DATA_WIDTH-1];
                        shift_q   <= shift_q << 1;
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                GAP: begin
                    if (!last_gap) begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                default: begin
                    data_out  <= 1'b0;
                    write_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
